alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (32-bit a/b, 4-bit op, 32-bit res) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready on both sides.
- Two-stage pipeline: an operand register drives the ALU, then a result register feeds a single response port tagged with the requester index.
- Sits between issue logic and the shared ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of rsp_id; must equal max(1, ceil(log2(NUM_REQ))).

Ports:
- clk  in  1  clock, rising edge.
- async_rst  in  1  asynchronous active-high reset.
- clk_en  in  1  global enable; when 0, all registers hold.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*32  operand a, requester i at [32i+31:32i].
- req_b  in  NUM_REQ*32  operand b, same packing.
- req_op  in  NUM_REQ*4  ALU op, requester i at [4i+3:4i].
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_op  out  4  to ALU op.
- alu_res  in  32  from ALU res.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  index of the requester owning rsp_res.
- rsp_res  out  32  result.
- rsp_err  out  1  illegal-op flag; tied 0 unless ALU_ARB_OPCHK_EN is defined.

Behaviour:
- Reset (async, immediate): s1_valid=0, rsp_valid=0, alu_a/alu_b/alu_op=0, rsp_id=0, rsp_res=0, rsp_err=0, rr_ptr=0. Any in-flight ops are discarded and never reported.
- Stage advance:
  - adv2 = s1_valid & (~rsp_valid | rsp_ready).
  - adv1 = ~s1_valid | adv2.
- Grant is combinational: the first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- req_ready[i] = clk_en & adv1 & grant[i]. A handshake is req_valid[i] & req_ready[i].
- On handshake (when clk_en=1):
  - operand register <= requester's a/b/op; s1_id <= i; s1_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - With no handshake, rr_ptr holds.
- If adv1 is true and there is no handshake, s1_valid <= 0.
- alu_a/alu_b/alu_op come directly from the operand register. They hold their last value when s1_valid=0.
- On adv2 (when clk_en=1): rsp_res <= alu_res, rsp_id <= s1_id, rsp_valid <= 1.
- If rsp_valid & rsp_ready with no adv2, rsp_valid <= 0.
- Latency: handshake at edge N gives rsp_valid=1 after edge N+1. Sustained throughput is 1 op/cycle when rsp_ready=1.
- Backpressure:
  - rsp_valid=1 & rsp_ready=0 with s1 full: all req_ready=0 and both stages hold.
  - rsp_res/rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous drain and fill: when the response is consumed, s1 moves to rsp and a new request enters s1 on the same edge.
- Fairness: a requester holding valid is granted within NUM_REQ grants.
- clk_en=0: no state changes, req_ready=0 for all requesters, and outputs hold.
- Ops 10..15 pass to the ALU unchanged unless opcode checking is enabled (see below).

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- Defined:
  - A request with op > 9 is still accepted and sequenced normally.
  - It is marked illegal in s1.
  - On adv2, rsp_res <= 0 and rsp_err <= 1, regardless of alu_res.
  - Legal ops load rsp_err <= 0.
- Undefined: no check; rsp_err is constant 0 and alu_res always passes through.

Test Plan:
- Single op: reset; req0 a=2, b=5, op=0 → req_ready[0]=1; after the next edge alu_a=2, alu_b=5; one edge later rsp_valid=1, rsp_id=0, rsp_res=7.
- Round-robin: req0 and req1 held valid continuously with rsp_ready=1 → grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; responses back-to-back.
- Backpressure: rsp_ready=0 with a response pending and s1 full → req_ready=0; rsp_res stays stable for 5 cycles. Raise rsp_ready → the held result drains, then s1 (a=3, b=2, op=4) yields rsp_res=1.
- clk_en: drop clk_en for 3 cycles mid-stream → no handshakes, rsp_valid/rsp_res and alu_a unchanged; the stream resumes with no lost or duplicated op.
- Async reset mid-operation: assert async_rst between edges with both stages full → rsp_valid=0 and alu_op=0 immediately; after release, the first response corresponds to the first post-reset request.
- ALU_ARB_OPCHK_EN defined: op=12, a=1, b=1 → rsp_valid=1, rsp_err=1, rsp_res=0. A following op=1 (a=2, b=5) → rsp_err=0, rsp_res=32'hFFFFFFFD.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NUM_REQ
// requesters. A two-stage pipeline of operand register then result register
// drives a single tagged response port.
// Optional feature: define ALU_ARB_OPCHK_EN to flag ops above 9 as illegal.
// Illegal ops return rsp_res=0 and rsp_err=1.
module alu_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = 1
) (
   input  logic                 clk,
   input  logic                 async_rst,
   input  logic                 clk_en,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   input  logic [NUM_REQ*4-1:0]  req_op,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   output logic [3:0]           alu_op,
   input  logic [31:0]          alu_res,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [31:0]          rsp_res,
   output logic                 rsp_err
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 4;

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    rr_next;
   logic [ID_W-1:0]    s1_id;
   logic               s1_valid;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_any;
   logic [DATA_W-1:0]  sel_a;
   logic [DATA_W-1:0]  sel_b;
   logic [OP_W-1:0]    sel_op;
   logic               adv1;
   logic               adv2;
   logic               hs;

   // Round-robin grant: search from rr_ptr upward, then wrap to index 0
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      grant   = '0;
      sel_a   = '0;
      sel_b   = '0;
      sel_op  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
            gnt_any  = 1'b1;
            gnt_id   = ID_W'(i);
            grant[i] = 1'b1;
            sel_a    = req_a[DATA_W*i +: DATA_W];
            sel_b    = req_b[DATA_W*i +: DATA_W];
            sel_op   = req_op[OP_W*i +: OP_W];
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && req_valid[i]) begin
            gnt_any  = 1'b1;
            gnt_id   = ID_W'(i);
            grant[i] = 1'b1;
            sel_a    = req_a[DATA_W*i +: DATA_W];
            sel_b    = req_b[DATA_W*i +: DATA_W];
            sel_op   = req_op[OP_W*i +: OP_W];
         end
      end
   end

   // Pipeline advance conditions and request handshake
   assign adv2      = s1_valid & (~rsp_valid | rsp_ready);
   assign adv1      = ~s1_valid | adv2;
   assign req_ready = {NUM_REQ{clk_en & adv1}} & grant;
   assign hs        = clk_en & adv1 & gnt_any;
   assign rr_next   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

   // Operand stage and round-robin pointer
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         rr_ptr   <= '0;
      end else if (clk_en) begin
         if (hs) begin
            s1_valid <= 1'b1;
            s1_id    <= gnt_id;
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_op   <= sel_op;
            rr_ptr   <= rr_next;
         end else if (adv1) begin
            s1_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_ARB_OPCHK_EN
   logic s1_ill;

   // Illegal-op marker travels alongside the operand stage
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         s1_ill <= 1'b0;
      end else if (clk_en && hs) begin
         s1_ill <= (sel_op > OP_W'(9));
      end
   end

   // Response stage with illegal-op squash
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_res   <= '0;
         rsp_err   <= 1'b0;
      end else if (clk_en) begin
         if (adv2) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s1_id;
            rsp_res   <= s1_ill ? '0 : alu_res;
            rsp_err   <= s1_ill;
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
`else
   assign rsp_err = 1'b0;

   // Response stage: capture ALU result for the operand-stage owner
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_res   <= '0;
      end else if (clk_en) begin
         if (adv2) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s1_id;
            rsp_res   <= alu_res;
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and a small ALU stub.
// Exercises ALU_ARB_OPCHK_EN expectations when that macro is defined.
module tb_alu_arbiter;

   logic          clk;
   logic          async_rst;
   logic          clk_en;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [63:0]   req_a;
   logic [63:0]   req_b;
   logic [7:0]    req_op;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic [3:0]    alu_op;
   logic [31:0]   alu_res;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [0:0]    rsp_id;
   logic [31:0]   rsp_res;
   logic          rsp_err;

   int errors = 0;
   int checks = 0;

   alu_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
      .clk       (clk),
      .async_rst (async_rst),
      .clk_en    (clk_en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_res   (alu_res),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_res   (rsp_res),
      .rsp_err   (rsp_err)
   );

   // ALU stub: 0 add, 1 sub, 2 and, 3 or, 4 xor, others add
   always_comb begin
      case (alu_op)
         4'd0:    alu_res = alu_a + alu_b;
         4'd1:    alu_res = alu_a - alu_b;
         4'd2:    alu_res = alu_a & alu_b;
         4'd3:    alu_res = alu_a | alu_b;
         4'd4:    alu_res = alu_a ^ alu_b;
         default: alu_res = alu_a + alu_b;
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
      if (idx == 0) begin
         req_a[31:0] = a;  req_b[31:0] = b;  req_op[3:0] = op;
      end else begin
         req_a[63:32] = a; req_b[63:32] = b; req_op[7:4] = op;
      end
   endtask

   initial begin
      async_rst = 1'b1;
      clk_en    = 1'b1;
      req_valid = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu_op",    32'(alu_op),    32'd0);
      chk("rst_rsp_res",   rsp_res,        32'd0);
      chk("rst_rsp_id",    32'(rsp_id),    32'd0);
      async_rst = 1'b0;

      // Single op: 2 + 5
      set_req(0, 32'd2, 32'd5, 4'd0);
      req_valid = 2'b01;
      #1;
      chk("single_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b00;
      chk("single_alu_a",  alu_a, 32'd2);
      chk("single_alu_b",  alu_b, 32'd5);
      chk("single_rv_early", 32'(rsp_valid), 32'd0);
      tick();
      chk("single_rv",  32'(rsp_valid), 32'd1);
      chk("single_id",  32'(rsp_id),    32'd0);
      chk("single_res", rsp_res,        32'd7);
      tick();
      chk("single_drain", 32'(rsp_valid), 32'd0);

      // Round-robin: pointer is at 1 after the single op
      set_req(0, 32'd10, 32'd1, 4'd0);
      set_req(1, 32'd20, 32'd3, 4'd1);
      req_valid = 2'b11;
      #1;
      chk("rr_gnt0", 32'(req_ready), 32'd2);
      tick();
      chk("rr_gnt1", 32'(req_ready), 32'd1);
      chk("rr_rv1",  32'(rsp_valid), 32'd0);
      tick();
      chk("rr_gnt2", 32'(req_ready), 32'd2);
      chk("rr_rv2",  32'(rsp_valid), 32'd1);
      chk("rr_id2",  32'(rsp_id),    32'd1);
      chk("rr_res2", rsp_res,        32'd17);
      tick();
      chk("rr_gnt3", 32'(req_ready), 32'd1);
      chk("rr_id3",  32'(rsp_id),    32'd0);
      chk("rr_res3", rsp_res,        32'd11);
      tick();
      req_valid = 2'b00;
      chk("rr_id4",  32'(rsp_id),    32'd1);
      chk("rr_res4", rsp_res,        32'd17);
      tick();
      chk("rr_rv5",  32'(rsp_valid), 32'd1);
      chk("rr_id5",  32'(rsp_id),    32'd0);
      chk("rr_res5", rsp_res,        32'd11);
      tick();
      chk("rr_idle", 32'(rsp_valid), 32'd0);

      // Backpressure: pointer at 1
      rsp_ready = 1'b0;
      set_req(1, 32'd7, 32'd8, 4'd0);
      req_valid = 2'b10;
      tick();
      set_req(0, 32'd3, 32'd2, 4'd4);
      req_valid = 2'b01;
      #1;
      chk("bp_fill_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b10;
      #1;
      chk("bp_rv",    32'(rsp_valid), 32'd1);
      chk("bp_res",   rsp_res,        32'd15);
      chk("bp_ready", 32'(req_ready), 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_hold_res",   rsp_res,        32'd15);
         chk("bp_hold_id",    32'(rsp_id),    32'd1);
         chk("bp_hold_ready", 32'(req_ready), 32'd0);
         chk("bp_hold_alu_a", alu_a,          32'd3);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      tick();
      chk("bp_drain_rv",  32'(rsp_valid), 32'd1);
      chk("bp_drain_id",  32'(rsp_id),    32'd0);
      chk("bp_drain_res", rsp_res,        32'd1);
      tick();
      chk("bp_idle", 32'(rsp_valid), 32'd0);

      // clk_en gap mid-stream: pointer at 1
      set_req(0, 32'd100, 32'd1, 4'd3);
      set_req(1, 32'd200, 32'd2, 4'd3);
      req_valid = 2'b11;
      tick();
      tick();
      clk_en = 1'b0;
      #1;
      chk("ce_ready", 32'(req_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ce_hold_rv",    32'(rsp_valid), 32'd1);
         chk("ce_hold_res",   rsp_res,        32'd202);
         chk("ce_hold_alu_a", alu_a,          32'd100);
         chk("ce_hold_ready", 32'(req_ready), 32'd0);
      end
      clk_en = 1'b1;
      #1;
      chk("ce_resume_ready", 32'(req_ready), 32'd2);
      tick();
      chk("ce_r1_id",  32'(rsp_id), 32'd0);
      chk("ce_r1_res", rsp_res,     32'd101);
      tick();
      chk("ce_r2_id",  32'(rsp_id), 32'd1);
      chk("ce_r2_res", rsp_res,     32'd202);
      chk("ce_alu_op", 32'(alu_op), 32'd3);

      // Async reset between edges with both stages full
      req_valid = 2'b00;
      #2;
      async_rst = 1'b1;
      #1;
      chk("ar_rv",     32'(rsp_valid), 32'd0);
      chk("ar_alu_op", 32'(alu_op),    32'd0);
      chk("ar_alu_a",  alu_a,          32'd0);
      #1;
      async_rst = 1'b0;
      tick();
      chk("ar_quiet", 32'(rsp_valid), 32'd0);
      set_req(1, 32'd9, 32'd4, 4'd1);
      req_valid = 2'b10;
      #1;
      chk("ar_ready", 32'(req_ready), 32'd2);
      tick();
      req_valid = 2'b00;
      chk("ar_no_stale", 32'(rsp_valid), 32'd0);
      tick();
      chk("ar_rv1",  32'(rsp_valid), 32'd1);
      chk("ar_id1",  32'(rsp_id),    32'd1);
      chk("ar_res1", rsp_res,        32'd5);
      tick();

      // Opcode 12 followed by a legal subtract
      set_req(0, 32'd1, 32'd1, 4'd12);
      req_valid = 2'b01;
      tick();
      set_req(0, 32'd2, 32'd5, 4'd1);
      tick();
      req_valid = 2'b00;
      chk("op_rv", 32'(rsp_valid), 32'd1);
`ifdef ALU_ARB_OPCHK_EN
      chk("op_ill_err", 32'(rsp_err), 32'd1);
      chk("op_ill_res", rsp_res,      32'd0);
`else
      chk("op_ill_err", 32'(rsp_err), 32'd0);
      chk("op_ill_res", rsp_res,      32'd2);
`endif
      tick();
      chk("op_leg_rv",  32'(rsp_valid), 32'd1);
      chk("op_leg_err", 32'(rsp_err),   32'd0);
      chk("op_leg_res", rsp_res,        32'hFFFFFFFD);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
